// File: rtl/ava_fetch_scheduler.sv
// ava_fetch_scheduler: credit-guarded pixel fetch sequencer feeding the async pixel FIFO.
// Optional stall statistics are enabled by defining AVA_FETCH_STATS_EN.
module ava_fetch_scheduler #(
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int ADDR_WIDTH    = 19,
   parameter int FETCH_LATENCY = 2,
   parameter int VBLANK_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  render_en,
   input  logic                  mode_in,
   output logic                  mode_active,
   output logic [ADDR_WIDTH-1:0] linear_coords,
   output logic                  fetch_en,
   input  logic [23:0]           pixel_in,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [23:0]           fifo_din,
   output logic                  vblank,
   output logic                  frame_start,
   output logic [15:0]           stall_count
);
   localparam int SKID_DEPTH = FETCH_LATENCY + 1;
   localparam int CW = $clog2(SKID_DEPTH + 1);
   localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int VW = (VBLANK_CYCLES > 1) ? $clog2(VBLANK_CYCLES) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, VBLANK} state_t;

   state_t                   state;
   logic [FETCH_LATENCY-1:0] vld;
   logic [23:0]              skid [SKID_DEPTH];
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic [CW-1:0]            skid_count, in_flight, used;
   logic [VW-1:0]            vb_cnt;
   logic                     capture, credit;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credits come only from registered occupancy, so fifo_full never reaches fetch_en
   assign in_flight   = CW'($countones(vld));
   assign used        = in_flight + skid_count;
   assign credit      = used < CW'(SKID_DEPTH);
   assign fetch_en    = (state == ACTIVE) && credit;
   assign frame_start = fetch_en && linear_coords == '0;
   assign capture     = vld[FETCH_LATENCY-1];
   assign fifo_wr_en  = !fifo_full && skid_count != '0;
   assign fifo_din    = skid[rd_ptr];
   assign vblank      = state == VBLANK;

   // Track fetches through the read latency and hold returning pixels until the FIFO accepts them
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         vld        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         skid_count <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) skid[i] <= '0;
      end else begin
         vld <= FETCH_LATENCY'({vld, fetch_en});
         if (capture) begin
            skid[wr_ptr] <= pixel_in;
            wr_ptr       <= nxt(wr_ptr);
         end
         if (fifo_wr_en) rd_ptr <= nxt(rd_ptr);
         skid_count <= skid_count + CW'(capture) - CW'(fifo_wr_en);
      end

   // Frame sequencer: addressing, per-frame mode latch and vblank timing
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state         <= IDLE;
         linear_coords <= '0;
         mode_active   <= 1'b0;
         vb_cnt        <= '0;
      end else
         case (state)
            IDLE: if (render_en) begin
               state         <= ACTIVE;
               mode_active   <= mode_in;
               linear_coords <= '0;
            end
            ACTIVE: if (fetch_en) begin
               if (linear_coords == LAST) state <= DRAIN;
               else linear_coords <= linear_coords + 1'b1;
            end
            DRAIN: if (in_flight == '0 && skid_count == '0) begin
               state  <= VBLANK;
               vb_cnt <= '0;
            end
            VBLANK: if (vb_cnt == VW'(VBLANK_CYCLES - 1)) begin
               state         <= render_en ? ACTIVE : IDLE;
               mode_active   <= render_en ? mode_in : mode_active;
               linear_coords <= '0;
            end else vb_cnt <= vb_cnt + 1'b1;
            default: state <= IDLE;
         endcase

`ifdef AVA_FETCH_STATS_EN
   logic [15:0] stalls;
   // Count credit-starved ACTIVE cycles, saturating, restarted by each frame start
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) stalls <= '0;
      else if (frame_start) stalls <= '0;
      else if (state == ACTIVE && !credit && stalls != 16'hFFFF) stalls <= stalls + 1'b1;
   assign stall_count = stalls;
`else
   assign stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_ava_fetch_scheduler.sv
// tb_ava_fetch_scheduler: scoreboard bench for ava_fetch_scheduler on an 8x4 frame.
module tb_ava_fetch_scheduler;
   localparam int H = 8, V = 4, AW = 5, VB = 20, N = H * V;

   logic          clk = 1'b0, reset_n = 1'b0, render_en = 1'b0, mode_in = 1'b0, fifo_full = 1'b0;
   logic          mode_active, fetch_en, fifo_wr_en, vblank, frame_start;
   logic [AW-1:0] linear_coords;
   logic [23:0]   pixel_in, fifo_din, p0, p1;
   logic [15:0]   stall_count;

   int          n_chk = 0, n_fail = 0, push_cnt = 0, fetch_cnt = 0, fs_cnt = 0;
   logic        exp_mode = 1'b0, rnd = 1'b0;
   logic [23:0] exp_q [$];

   ava_fetch_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .FETCH_LATENCY(2),
                         .VBLANK_CYCLES(VB)) dut (
      .clk(clk), .reset_n(reset_n), .render_en(render_en), .mode_in(mode_in),
      .mode_active(mode_active), .linear_coords(linear_coords), .fetch_en(fetch_en),
      .pixel_in(pixel_in), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .vblank(vblank), .frame_start(frame_start), .stall_count(stall_count));

   always #5 clk = ~clk;

   function automatic logic [23:0] px(input int a);
      logic [7:0] b;
      b = 8'(a);
      return {8'hC3, b, ~b};
   endfunction

   // Two-cycle VRAM + palette model
   always @(posedge clk) begin
      p0 <= fetch_en ? px(int'(linear_coords)) : 24'hDEAD00;
      p1 <= p0;
   end
   assign pixel_in = p1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every push, checks mode and frame start
   always @(negedge clk) if (reset_n) begin
      if (fifo_wr_en) begin
         chk("wr_while_full", 32'(fifo_full), 0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_push: got %0h expected no push", fifo_din);
         end else chk("push_data", 32'(fifo_din), 32'(exp_q.pop_front()));
         push_cnt++;
      end
      if (fetch_en) begin
         fetch_cnt++;
         chk("mode_active", 32'(mode_active), 32'(exp_mode));
      end
      if (frame_start) begin
         fs_cnt++;
         chk("frame_start_addr", 32'(linear_coords), 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd) fifo_full = 1'($urandom_range(0, 1));
   endtask

   task automatic load_frame();
      for (int i = 0; i < N; i++) exp_q.push_back(px(i));
   endtask

   task automatic wait_fetch(input int idx, input string name);
      int n = 0;
      while (!(fetch_en && int'(linear_coords) == idx) && n < 3000) begin step(); n++; end
      chk({name, "_reached"}, 32'(n < 3000), 1);
   endtask

   task automatic wait_vblank(input string name);
      int n = 0;
      while (!vblank && n < 5000) begin step(); n++; end
      chk({name, "_vblank_seen"}, 32'(vblank), 1);
      chk({name, "_all_pushed"}, exp_q.size(), 0);
   endtask

   task automatic vblank_len(input string name);
      int len = 0;
      while (vblank && len < 5000) begin step(); len++; end
      chk({name, "_vblank_len"}, len, VB);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_fetch_en"}, 32'(fetch_en), 0);
      chk({tag, "_fifo_wr_en"}, 32'(fifo_wr_en), 0);
      chk({tag, "_fifo_din"}, 32'(fifo_din), 0);
      chk({tag, "_linear_coords"}, 32'(linear_coords), 0);
      chk({tag, "_vblank"}, 32'(vblank), 0);
      chk({tag, "_frame_start"}, 32'(frame_start), 0);
      chk({tag, "_mode_active"}, 32'(mode_active), 0);
      chk({tag, "_stall_count"}, 32'(stall_count), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fc, pc, n;
      logic [15:0] sc;
      step();
      step();
      check_zero("reset");
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("idle_no_fetch", fetch_cnt, 0);
      // Frame 0: mode request changes mid-frame and must be ignored
      load_frame();
      render_en = 1'b1;
      wait_fetch(10, "f0_px10");
      mode_in = 1'b1;
      wait_vblank("f0");
      exp_mode = 1'b1;
      load_frame();
      vblank_len("f0");
      // Frame 1: backpressure from push 5 for 20 cycles
      n = 0;
      while (push_cnt != N + 5 && n < 3000) begin step(); n++; end
      chk("f1_push5_reached", 32'(n < 3000), 1);
      fifo_full = 1'b1;
      fc = fetch_cnt;
      pc = push_cnt;
      sc = stall_count;
      for (int i = 0; i < 20; i++) step();
      fifo_full = 1'b0;
      chk("bp_fetches_le3", 32'(fetch_cnt - fc <= 3), 1);
      chk("bp_no_push", push_cnt - pc, 0);
`ifdef AVA_FETCH_STATS_EN
      chk("bp_stall_delta", 32'(int'(stall_count - sc) >= 16 && int'(stall_count - sc) <= 20), 1);
`else
      chk("bp_stall_zero", 32'(stall_count), 32'(sc));
      chk("stall_tied", 32'(stall_count), 0);
`endif
      wait_vblank("f1");
      load_frame();
      vblank_len("f1");
      // Frame 2: random backpressure, render_en dropped at pixel 12
      rnd = 1'b1;
      wait_fetch(12, "f2_px12");
      render_en = 1'b0;
      wait_vblank("f2");
      vblank_len("f2");
      rnd = 1'b0;
      fifo_full = 1'b0;
      fc = fetch_cnt;
      for (int i = 0; i < 30; i++) step();
      chk("idle_after_drop_fetch", fetch_cnt - fc, 0);
      chk("idle_after_drop_vblank", 32'(vblank), 0);
      // Frame 3: asynchronous reset at pixel 7
      load_frame();
      render_en = 1'b1;
      wait_fetch(7, "f3_px7");
      reset_n = 1'b0;
      #1;
      check_zero("midreset");
      exp_q.delete();
      step();
      load_frame();
      reset_n = 1'b1;
      // Frame 4: restarts from index 0 and runs to completion
      wait_fetch(20, "f4_px20");
      render_en = 1'b0;
      wait_vblank("f4");
      vblank_len("f4");
      chk("frame_start_count", fs_cnt, 5);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
